// File: rtl/adc_pkg.sv
// Shared types and defaults for the multi-lane ADC frame reader.
package adc_pkg;
    typedef enum logic [1:0] {SYNC, IDLE, SHIFT} adc_state_e;

    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4;

    function automatic int unsigned fill_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/adc_frame_reader_if.sv
// Downstream result handshake: FIFO head data with valid/ready.
interface adc_frame_reader_if
    import adc_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned WORD_W = WORD_W_DEF
);
    logic [NUM_CH*WORD_W-1:0] result_data;
    logic                     result_valid;
    logic                     result_ready;

    modport master (output result_data, output result_valid, input result_ready);
    modport slave  (input result_data, input result_valid, output result_ready);
endinterface

// File: rtl/adc_frame_fifo.sv
// Show-ahead frame FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module adc_frame_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned FW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             push_ok,
    input  logic             pop_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [FW-1:0]    fill
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    cnt_q, cnt_d;
    logic             full, pop;

    always_comb begin
        full     = (cnt_q == FW'(DEPTH));
        rd_valid = (cnt_q != '0);
        pop      = pop_req && rd_valid;
        push_ok  = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d   = cnt_q + FW'(push_ok) - FW'(pop);
        rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
        fill    = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/adc_frame_reader.sv
// Multi-lane serial ADC frame receiver feeding a show-ahead FIFO.
// Define ADC_FRAME_LEN_CHECK_EN to reject frames whose length differs from WORD_W.
module adc_frame_reader
    import adc_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned FILL_W = fill_width(DEPTH)
) (
    input  logic                SCO,
    input  logic                reset,
    input  logic                FSO,
    input  logic [NUM_CH-1:0]   SDO,
    input  logic                ADCSTATUS1,
    adc_frame_reader_if.master  res,
    output logic                ADCSTATUS2,
    output logic                frame_err,
    output logic                overflow,
    output logic [FILL_W-1:0]   fill
);
    logic [1:0]                     rst_sync_q;
    logic                           rst_n;
    adc_state_e                     state_q, state_d;
    logic [NUM_CH-1:0][WORD_W-1:0]  sh_q, sh_d;
    logic                           cap_en_q, cap_en_d;
    logic                           status2_q, status2_d;
    logic                           overflow_q, overflow_d;
    logic                           end_frame, len_ok, commit, push_ok;

    // Assert asynchronously, release on the second SCO edge.
    always_ff @(posedge SCO or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

`ifdef ADC_FRAME_LEN_CHECK_EN
    localparam int unsigned CNT_W = $clog2(WORD_W + 2);
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             frame_err_q, frame_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cap_en_d  = cap_en_q;
        end_frame = 1'b0;
`ifdef ADC_FRAME_LEN_CHECK_EN
        bit_cnt_d = bit_cnt_q;
`endif
        unique case (state_q)
            SYNC: if (FSO) state_d = IDLE;
            IDLE: begin
                if (!FSO) begin
                    state_d  = SHIFT;
                    cap_en_d = ADCSTATUS1;
                    for (int unsigned ch = 0; ch < NUM_CH; ch++) sh_d[ch] = WORD_W'(SDO[ch]);
`ifdef ADC_FRAME_LEN_CHECK_EN
                    bit_cnt_d = CNT_W'(1);
`endif
                end
            end
            SHIFT: begin
                if (!FSO) begin
                    for (int unsigned ch = 0; ch < NUM_CH; ch++)
                        sh_d[ch] = {sh_q[ch][WORD_W-2:0], SDO[ch]};
`ifdef ADC_FRAME_LEN_CHECK_EN
                    if (bit_cnt_q != CNT_W'(WORD_W + 1)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
`endif
                end else begin
                    state_d   = IDLE;
                    end_frame = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase

`ifdef ADC_FRAME_LEN_CHECK_EN
        len_ok      = (bit_cnt_q == CNT_W'(WORD_W));
        frame_err_d = frame_err_q | (end_frame && cap_en_q && !len_ok);
`else
        len_ok      = 1'b1;
`endif
        commit     = end_frame && cap_en_q && len_ok;
        status2_d  = push_ok;
        overflow_d = overflow_q | (commit && !push_ok);
    end

    always_ff @(posedge SCO or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SYNC;
            sh_q       <= '0;
            cap_en_q   <= 1'b0;
            status2_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cap_en_q   <= cap_en_d;
            status2_q  <= status2_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef ADC_FRAME_LEN_CHECK_EN
    always_ff @(posedge SCO or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign ADCSTATUS2 = status2_q;
    assign overflow   = overflow_q;

    adc_frame_fifo #(
        .WIDTH (NUM_CH * WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (SCO),
        .rst_n    (rst_n),
        .push     (commit),
        .wdata    (sh_q),
        .push_ok  (push_ok),
        .pop_req  (res.result_ready),
        .rd_data  (res.result_data),
        .rd_valid (res.result_valid),
        .fill     (fill)
    );
endmodule

// File: tb/tb_adc_frame_reader.sv
// Scoreboard bench for adc_frame_reader with NUM_CH=2, WORD_W=16, DEPTH=4.
module tb_adc_frame_reader;
    logic       SCO = 1'b0;
    logic       reset;
    logic       FSO;
    logic [1:0] SDO;
    logic       ADCSTATUS1;
    logic       ADCSTATUS2;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fill;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] sb_q [$];

`ifdef ADC_FRAME_LEN_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    adc_frame_reader_if #(.NUM_CH(2), .WORD_W(16)) res ();

    adc_frame_reader #(.NUM_CH(2), .WORD_W(16), .DEPTH(4)) dut (
        .SCO        (SCO),
        .reset      (reset),
        .FSO        (FSO),
        .SDO        (SDO),
        .ADCSTATUS1 (ADCSTATUS1),
        .res        (res),
        .ADCSTATUS2 (ADCSTATUS2),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fill       (fill)
    );

    always #5 SCO = ~SCO;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every accepted head must match the oldest expected frame.
    always @(negedge SCO) begin
        if (res.result_valid && res.result_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pop", 64'(res.result_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("frame_data", 64'(res.result_data), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1, input int nbits,
                              input logic en_fall, input logic en_mid, input logic pop_at_end,
                              output logic pre_pulse);
        for (int k = 0; k < nbits; k++) begin
            FSO        = 1'b0;
            ADCSTATUS1 = (k < nbits / 2) ? en_fall : en_mid;
            SDO[0]     = w0[nbits-1-k];
            SDO[1]     = w1[nbits-1-k];
            @(posedge SCO); #1;
        end
        FSO = 1'b1;
        SDO = '0;
        if (pop_at_end) res.result_ready = 1'b1;
        @(negedge SCO);
        pre_pulse = ADCSTATUS2;
        @(posedge SCO); #1;
        if (pop_at_end) res.result_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        res.result_ready = 1'b1;
        for (int c = 0; c < 20 && res.result_valid; c++) begin
            @(posedge SCO); #1;
        end
        @(negedge SCO);
        check(name, 64'(fill), 64'd0);
        check({name, "_valid"}, 64'(res.result_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic pre;
        logic seen;
        reset = 1'b0; FSO = 1'b1; SDO = '0; ADCSTATUS1 = 1'b0; res.result_ready = 1'b1;
        #13;
        check("rst_valid", 64'(res.result_valid), 64'd0);
        check("rst_data",  64'(res.result_data), 64'd0);
        check("rst_stat2", 64'(ADCSTATUS2), 64'd0);
        check("rst_ferr",  64'(frame_err), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_fill",  64'(fill), 64'd0);
        #10 reset = 1'b1;
        repeat (5) @(posedge SCO);
        #1;

        // Basic frame, ready held high.
        sb_q.push_back(32'h0F0F_A5C3);
        send_frame(32'hA5C3, 32'h0F0F, 16, 1'b1, 1'b1, 1'b0, pre);
        check("basic_pre_pulse", 64'(pre), 64'd0);
        @(negedge SCO);
        check("basic_pulse", 64'(ADCSTATUS2), 64'd1);
        check("basic_valid", 64'(res.result_valid), 64'd1);
        check("basic_fill",  64'(fill), 64'd1);
        @(negedge SCO);
        check("basic_pulse_end", 64'(ADCSTATUS2), 64'd0);
        check("basic_popped", 64'(fill), 64'd0);
        @(posedge SCO); #1;

        // Short and long frames.
        if (!ERR_EXP) sb_q.push_back(32'h1234_5A5A);
        send_frame(32'h5A5A, 32'h1234, 15, 1'b1, 1'b1, 1'b0, pre);
        @(negedge SCO);
        check("short_pulse", 64'(ADCSTATUS2), 64'(!ERR_EXP));
        check("short_ferr",  64'(frame_err), 64'(ERR_EXP));
        @(posedge SCO); #1;
        if (!ERR_EXP) sb_q.push_back(32'hF00F_ABCD);
        send_frame(32'h1ABCD, 32'h0F00F, 17, 1'b1, 1'b1, 1'b0, pre);
        @(negedge SCO);
        check("long_pulse", 64'(ADCSTATUS2), 64'(!ERR_EXP));
        check("long_ferr",  64'(frame_err), 64'(ERR_EXP));
        @(posedge SCO); #1;
        drain("len_drain");
        @(posedge SCO); #1;

        // Fill to full, then push a 5th frame in the same cycle as a pop.
        res.result_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sb_q.push_back({16'h2000 + 16'(k), 16'h1000 + 16'(k)});
            send_frame(32'h1000 + k, 32'h2000 + k, 16, 1'b1, 1'b1, 1'b0, pre);
            @(negedge SCO);
            check("pp_fill", 64'(fill), 64'(k));
            @(posedge SCO); #1;
        end
        sb_q.push_back(32'h2005_1005);
        send_frame(32'h1005, 32'h2005, 16, 1'b1, 1'b1, 1'b1, pre);
        @(negedge SCO);
        check("pp_pulse", 64'(ADCSTATUS2), 64'd1);
        check("pp_fill_full", 64'(fill), 64'd4);
        check("pp_ovf", 64'(overflow), 64'd0);
        @(posedge SCO); #1;
        drain("pp_drain");
        @(posedge SCO); #1;

        // Overflow: five frames with ready low, the 5th is lost.
        res.result_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) sb_q.push_back({16'h4000 + 16'(k), 16'h3000 + 16'(k)});
            send_frame(32'h3000 + k, 32'h4000 + k, 16, 1'b1, 1'b1, 1'b0, pre);
            @(negedge SCO);
            if (k == 4) check("ovf_before", 64'(overflow), 64'd0);
            @(posedge SCO); #1;
        end
        @(negedge SCO);
        check("ovf_fill", 64'(fill), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        @(posedge SCO); #1;
        drain("ovf_drain");
        check("ovf_sb_empty", 64'(sb_q.size()), 64'd0);
        @(posedge SCO); #1;

        // Capture enable low at the FSO fall, raised mid-frame.
        res.result_ready = 1'b1;
        send_frame(32'h1111, 32'h2222, 16, 1'b0, 1'b1, 1'b0, pre);
        @(negedge SCO);
        check("capen_pulse", 64'(ADCSTATUS2), 64'd0);
        check("capen_fill",  64'(fill), 64'd0);
        check("capen_ovf",   64'(overflow), 64'd1);
        check("capen_ferr",  64'(frame_err), 64'(ERR_EXP));
        @(posedge SCO); #1;
        sb_q.push_back(32'h4444_3333);
        send_frame(32'h3333, 32'h4444, 16, 1'b1, 1'b1, 1'b0, pre);
        @(negedge SCO);
        check("capen_next_pulse", 64'(ADCSTATUS2), 64'd1);
        @(posedge SCO); #1;

        // Reset mid-frame with one frame queued.
        res.result_ready = 1'b0;
        sb_q.push_back(32'h6666_5555);
        send_frame(32'h5555, 32'h6666, 16, 1'b1, 1'b1, 1'b0, pre);
        @(negedge SCO);
        check("mid_fill_pre", 64'(fill), 64'd1);
        @(posedge SCO); #1;
        FSO = 1'b0; SDO = 2'b11; ADCSTATUS1 = 1'b1;
        repeat (8) begin @(posedge SCO); #1; end
        reset = 1'b0;
        #2;
        sb_q.delete();
        check("mid_valid", 64'(res.result_valid), 64'd0);
        check("mid_data",  64'(res.result_data), 64'd0);
        check("mid_fill",  64'(fill), 64'd0);
        check("mid_ovf",   64'(overflow), 64'd0);
        check("mid_ferr",  64'(frame_err), 64'd0);
        check("mid_stat2", 64'(ADCSTATUS2), 64'd0);
        repeat (3) begin @(posedge SCO); #1; end
        reset = 1'b1;
        repeat (6) begin @(posedge SCO); #1; end
        FSO = 1'b1; SDO = '0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge SCO);
            if (ADCSTATUS2) seen = 1'b1;
        end
        check("mid_no_commit", 64'(seen), 64'd0);
        check("mid_fill_after", 64'(fill), 64'd0);
        @(posedge SCO); #1;
        res.result_ready = 1'b1;
        sb_q.push_back(32'hCAFE_BEEF);
        send_frame(32'hBEEF, 32'hCAFE, 16, 1'b1, 1'b1, 1'b0, pre);
        @(negedge SCO);
        check("post_rst_pulse", 64'(ADCSTATUS2), 64'd1);
        repeat (3) @(negedge SCO);
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_frame_reader.md
# adc_frame_reader

Parametrised multi-lane serial ADC frame receiver for the sensor-readout path. Captures `WORD_W`-bit MSB-first words on `NUM_CH` parallel SDO lanes that share one frame-sync (`FSO`) and serial clock (`SCO`). Each completed frame goes into a `DEPTH`-entry FIFO and is presented downstream with a valid/ready handshake. The block adds frame-length checking, overflow detection and backpressure, none of which the previous single-lane reader had.

## Interface
- `NUM_CH`, 4: number of SDO lanes, 1..16.
- `WORD_W`, 32: bits per word per lane, 8..32.
- `DEPTH`, 4: FIFO depth in frames, power of two, 2..16.
- `SCO` input 1: ADC serial clock, the block's only clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `FSO` input 1: frame sync; low = data bits valid, rising edge = frame end.
- `SDO` input `NUM_CH`: serial data, bit i = lane i.
- `ADCSTATUS1` input 1: capture enable; sampled on the FSO falling edge.
- `result_data` output `NUM_CH*WORD_W`: FIFO head; lane i at bits [i*WORD_W +: WORD_W].
- `result_valid` output 1: FIFO not empty.
- `result_ready` input 1: downstream accepts the head.
- `ADCSTATUS2` output 1: one-cycle pulse when a frame is committed to the FIFO.
- `frame_err` output 1: sticky flag for a length-mismatched frame.
- `overflow` output 1: sticky flag for a frame dropped because the FIFO was full.
- `fill` output clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FSM states:
  - SYNC (after reset): wait for FSO=1, then go to IDLE. This discards any partial frame in progress at reset release.
  - IDLE: on FSO=0, go to SHIFT. Latch `ADCSTATUS1` as `cap_en`, clear the bit counter, and shift this cycle's SDO as bit 1.
  - SHIFT: while FSO=0, shift each lane left, inserting SDO at the LSB. `bit_cnt` increments and saturates at WORD_W+1. On FSO=1, go to IDLE and perform the commit check.
- Commit check:
  - Commit when `cap_en`=1 and the length is OK.
  - Length OK means `bit_cnt`==WORD_W (feature-dependent, see Configuration).
  - A failed length check sets `frame_err`; the frame is not written.
- Commit with FIFO not full: write all lane registers as one entry and pulse ADCSTATUS2.
- Commit with FIFO full and no pop in the same cycle: drop the frame, set `overflow`, do not pulse ADCSTATUS2.
- Push and pop in the same cycle while full: both succeed and `fill` is unchanged.
- Pop: when `result_valid` && `result_ready`, advance the head. `result_ready` while empty is ignored.
- `cap_en`=0: the frame is shifted but discarded; no flags change.
- Sticky flags clear only on reset.

## Timing
- Reset values: `result_data`=0, `result_valid`=0, `ADCSTATUS2`=0, `frame_err`=0, `overflow`=0, `fill`=0; FSM=SYNC; shift registers and counter = 0.
- Reset is asserted asynchronously and released synchronously to SCO through a 2-flop synchroniser.
- Reset mid-frame: the partial frame is lost and the FIFO is emptied.
- Latency: if the FSO rising edge is sampled at cycle N, then ADCSTATUS2, `result_valid` and the updated `fill` are seen at cycle N+1.
- FIFO is show-ahead: `result_data` is valid in the same cycle as `result_valid`.
- After a pop at cycle M, the next entry or `result_valid`=0 appears at M+1.
- A new frame may begin (FSO falls) at cycle N+1 with no dead cycle required.

## Configuration
- `ADC_FRAME_LEN_CHECK_EN` defined:
  - Commit only when `bit_cnt`==WORD_W; otherwise set `frame_err`.
- Undefined:
  - Every frame with `cap_en`=1 is committed, holding the last WORD_W bits shifted.
  - Zero-extended if fewer bits were shifted.
  - `frame_err` is tied to 0.
  - `bit_cnt` saturation logic is removed.

## Structure
- Package `adc_pkg` holds:
  - the FSM state enum (SYNC, IDLE, SHIFT);
  - default values for NUM_CH, WORD_W and DEPTH;
  - a `clog2`-based width constant for `fill`.
- Sub-module `adc_frame_fifo`: synchronous show-ahead FIFO of width NUM_CH*WORD_W, with same-cycle push/pop-when-full support.

## Test plan
- NUM_CH=2, WORD_W=16, ready held high; lane0 sends 0xA5C3 and lane1 sends 0x0F0F over 16 FSO-low cycles. Required: `result_data`=0x0F0FA5C3, with `result_valid` and ADCSTATUS2 high exactly one cycle after the sampled FSO rising edge.
- Frame with 15 bits, then with 17 bits, with the macro defined. Required: no commit and `frame_err`=1 after the first bad frame. With the macro undefined, both frames commit: the 15-bit word is zero-extended and the 17-bit word keeps its last 16 bits.
- DEPTH=4 and `result_ready`=0 for 5 frames. Required: `fill`=4, `overflow`=1, the 5th frame lost, and a later pop sequence yields frames 1–4 in order.
- FIFO full, a 5th frame ends in the same cycle as a pop. Required: the frame is accepted, `fill` stays 4, `overflow` stays 0.
- `ADCSTATUS1`=0 at the FSO fall, then set to 1 mid-frame. Required: the frame is discarded and no ADCSTATUS2 pulse occurs; the next frame with enable=1 commits.
- Reset asserted at bit 8 and released while FSO=0. Required: all outputs go to 0 and that partial frame is ignored (FSM stays in SYNC until FSO=1); the following full frame commits correctly.
